// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the ID/WB stages and pipe_hazard_ctrl.
// The controller takes the slave view; the pipeline (or a bench) takes the master view.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 6
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs_a;
  logic [REG_W-1:0] id_rs_b;
  logic             id_use_a;
  logic             id_use_b;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_branch_taken;
  logic             wb_redirect;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exwb_flush;
  logic [15:0]      stall_cnt;
  logic [15:0]      flush_cnt;

  modport master (
    output id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_rd, id_reg_write,
           id_branch_taken, wb_redirect,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, exwb_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_rd, id_reg_write,
           id_branch_taken, wb_redirect,
    output pc_en, ifid_en, ifid_flush, idex_bubble, exwb_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// RAW-stall / redirect-flush sequencer for the four-stage pipeline (no forwarding).
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_W            = 6,
  parameter int REDIRECT_PENALTY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  localparam logic [2:0] PEN_M1 = 3'(REDIRECT_PENALTY - 1);

  state_t           state_r, state_s;
  logic [2:0]       fcnt_r, fcnt_s;
  logic             ex_v_r, wb_v_r;
  logic [REG_W-1:0] ex_rd_r, wb_rd_r;

  logic hz_s;
  logic pc_s, ifen_s, iff_s, bub_s, exf_s;
  logic stall_inc_s, flush_inc_s, clr_sb_s;

  function automatic logic sb_match(input logic ex_v, input logic [REG_W-1:0] ex_rd,
                                    input logic wb_v, input logic [REG_W-1:0] wb_rd,
                                    input logic [REG_W-1:0] r);
    return (ex_v & (ex_rd == r)) | (wb_v & (wb_rd == r));
  endfunction

  // RAW hazard: the WB slot also counts because the register file has no read-through
  always_comb begin
    hz_s = bus.id_valid &
           ((bus.id_use_a & sb_match(ex_v_r, ex_rd_r, wb_v_r, wb_rd_r, bus.id_rs_a)) |
            (bus.id_use_b & sb_match(ex_v_r, ex_rd_r, wb_v_r, wb_rd_r, bus.id_rs_b)));
  end

  // Next-state and control decode
  always_comb begin
    state_s     = state_r;
    fcnt_s      = fcnt_r;
    pc_s        = 1'b1;
    ifen_s      = 1'b1;
    iff_s       = 1'b0;
    bub_s       = 1'b0;
    exf_s       = 1'b0;
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    clr_sb_s    = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (bus.wb_redirect) begin
          iff_s       = 1'b1;
          bub_s       = 1'b1;
          exf_s       = 1'b1;
          flush_inc_s = 1'b1;
          clr_sb_s    = 1'b1;
          fcnt_s      = PEN_M1;
          state_s     = (PEN_M1 == 3'd0) ? ST_RUN : ST_FLUSH;
        end else if (hz_s) begin
          pc_s        = 1'b0;
          ifen_s      = 1'b0;
          bub_s       = 1'b1;
          stall_inc_s = 1'b1;
        end else if (bus.id_branch_taken) begin
          iff_s = 1'b1;
        end else begin
          iff_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        iff_s = 1'b1;
        bub_s = 1'b1;
        // A jump reaching WB during the flush window restarts the window
        if (bus.wb_redirect) begin
          exf_s       = 1'b1;
          flush_inc_s = 1'b1;
          clr_sb_s    = 1'b1;
          fcnt_s      = PEN_M1;
          state_s     = (PEN_M1 == 3'd0) ? ST_RUN : ST_FLUSH;
        end else begin
          fcnt_s  = fcnt_r - 3'd1;
          state_s = (fcnt_r <= 3'd1) ? ST_RUN : ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_RUN;
        fcnt_s  = 3'd0;
      end
    endcase
  end

  // State and flush-window counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      fcnt_r  <= 3'd0;
    end else begin
      state_r <= state_s;
      fcnt_r  <= fcnt_s;
    end
  end

  // Scoreboard mirroring EX_M and WB destination registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_r  <= 1'b0;
      ex_rd_r <= {REG_W{1'b0}};
      wb_v_r  <= 1'b0;
      wb_rd_r <= {REG_W{1'b0}};
    end else if (clr_sb_s) begin
      ex_v_r  <= 1'b0;
      ex_rd_r <= {REG_W{1'b0}};
      wb_v_r  <= 1'b0;
      wb_rd_r <= {REG_W{1'b0}};
    end else begin
      wb_v_r  <= ex_v_r;
      wb_rd_r <= ex_rd_r;
      ex_v_r  <= bus.id_valid & bus.id_reg_write & ~bub_s;
      ex_rd_r <= bus.id_rd;
    end
  end

  assign bus.pc_en       = rst_n & pc_s;
  assign bus.ifid_en     = rst_n & ifen_s;
  assign bus.ifid_flush  = ~rst_n | iff_s;
  assign bus.idex_bubble = ~rst_n | bub_s;
  assign bus.exwb_flush  = ~rst_n | exf_s;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  // Saturating stall / redirect event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      if (stall_inc_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.stall_cnt = rst_n ? stall_cnt_r : 16'h0000;
  assign bus.flush_cnt = rst_n ? flush_cnt_r : 16'h0000;
`else
  logic perf_unused_s;
  assign perf_unused_s = stall_inc_s ^ flush_inc_s;
  assign bus.stall_cnt = 16'h0000;
  assign bus.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// against an in-flight-register reference model.
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 6;
  localparam int PEN   = 2;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(REG_W)) bus ();

  pipe_hazard_ctrl #(.REG_W(REG_W), .REDIRECT_PENALTY(PEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // {pc_en, ifid_en, ifid_flush, idex_bubble, exwb_flush}
  logic [4:0] ctl;
  assign ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.exwb_flush};

  // Reference model: registers still in flight (-1 = empty), flush cycles left, event counts
  int m_ex, m_wb, m_fl, m_sc, m_fc;
  logic [4:0] e_ctl;
  bit e_stall;

  function automatic bit in_flight(input int r);
    return (m_ex == r) || (m_wb == r);
  endfunction

  function automatic void model_eval();
    bit hz;
    hz = bus.id_valid && ((bus.id_use_a && in_flight(int'(bus.id_rs_a))) ||
                          (bus.id_use_b && in_flight(int'(bus.id_rs_b))));
    e_stall = 1'b0;
    if (!rst_n) e_ctl = 5'b00111;
    else if (bus.wb_redirect) e_ctl = 5'b11111;
    else if (m_fl > 0) e_ctl = 5'b11110;
    else if (hz) begin e_ctl = 5'b00010; e_stall = 1'b1; end
    else if (bus.id_branch_taken) e_ctl = 5'b11100;
    else e_ctl = 5'b11000;
  endfunction

  function automatic logic [15:0] exp_cnt(input int v);
    if (!PERF || !rst_n) return 16'h0000;
    return v[15:0];
  endfunction

  task automatic drive(input bit v, input int ra, input bit ua, input int rb, input bit ub,
                       input int rd, input bit rw, input bit br, input bit rdr);
    bus.id_valid        = v;
    bus.id_rs_a         = ra[REG_W-1:0];
    bus.id_use_a        = ua;
    bus.id_rs_b         = rb[REG_W-1:0];
    bus.id_use_b        = ub;
    bus.id_rd           = rd[REG_W-1:0];
    bus.id_reg_write    = rw;
    bus.id_branch_taken = br;
    bus.wb_redirect     = rdr;
  endtask

  // Advance one clock from a negedge to the next, updating the model at the rising edge
  task automatic step();
    model_eval();
    @(posedge clk);
    if (!rst_n) begin
      m_ex = -1; m_wb = -1; m_fl = 0; m_sc = 0; m_fc = 0;
    end else if (bus.wb_redirect) begin
      m_ex = -1; m_wb = -1; m_fl = PEN - 1;
      if (m_fc < 65535) m_fc++;
    end else begin
      m_wb = m_ex;
      m_ex = (bus.id_valid && bus.id_reg_write && !e_ctl[1]) ? int'(bus.id_rd) : -1;
      if (m_fl > 0) m_fl--;
      if (e_stall && m_sc < 65535) m_sc++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1),
            $urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 63),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      #1;
      checks++;
      if (ctl !== 5'b00111) begin
        errors++; $display("FAIL reset_ctl cyc %0d got %b exp %b", i, ctl, 5'b00111);
      end
      checks++;
      if (bus.stall_cnt !== 16'h0000 || bus.flush_cnt !== 16'h0000) begin
        errors++; $display("FAIL reset_cnt got %h/%h exp 0000/0000", bus.stall_cnt, bus.flush_cnt);
      end
      step();
    end
    rst_n = 1'b1;
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
    #1;
    checks++;
    if (ctl !== 5'b11000) begin
      errors++; $display("FAIL reset_release got %b exp %b", ctl, 5'b11000);
    end
    step();
    idle(2);
  endtask

  task automatic test_raw_stall();
    int sc0;
    idle(2);
    sc0 = m_sc;
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    step();
    drive(1, 5, 1, 0, 0, 9, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== 5'b00010) begin
        errors++; $display("FAIL raw_stall cyc %0d got %b exp %b", i, ctl, 5'b00010);
      end
      step();
    end
    #1;
    checks++;
    if (ctl !== 5'b11000) begin
      errors++; $display("FAIL raw_issue got %b exp %b", ctl, 5'b11000);
    end
    checks++;
    if (bus.stall_cnt !== exp_cnt(sc0 + 2)) begin
      errors++; $display("FAIL raw_stall_cnt got %h exp %h", bus.stall_cnt, exp_cnt(sc0 + 2));
    end
    step();
  endtask

  task automatic test_wb_distance();
    idle(2);
    drive(1, 0, 0, 0, 0, 12, 1, 0, 0);
    step();
    drive(1, 4, 1, 0, 0, 3, 1, 0, 0);
    #1;
    checks++;
    if (ctl !== 5'b11000) begin
      errors++; $display("FAIL wb_indep got %b exp %b", ctl, 5'b11000);
    end
    step();
    drive(1, 0, 0, 12, 1, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== 5'b00010) begin
      errors++; $display("FAIL wb_stall got %b exp %b", ctl, 5'b00010);
    end
    step();
    #1;
    checks++;
    if (ctl !== 5'b11000) begin
      errors++; $display("FAIL wb_issue got %b exp %b", ctl, 5'b11000);
    end
    step();
    idle(2);
    drive(1, 0, 0, 0, 0, 12, 1, 0, 0);
    step();
    drive(1, 12, 0, 12, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== 5'b11000) begin
      errors++; $display("FAIL wb_unused_src got %b exp %b", ctl, 5'b11000);
    end
    step();
  endtask

  task automatic test_branch();
    idle(2);
    drive(1, 1, 1, 2, 1, 3, 0, 1, 0);
    #1;
    checks++;
    if (ctl !== 5'b11100) begin
      errors++; $display("FAIL branch got %b exp %b", ctl, 5'b11100);
    end
    step();
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0);
    step();
    drive(1, 8, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== 5'b00010) begin
        errors++; $display("FAIL branch_hz cyc %0d got %b exp %b", i, ctl, 5'b00010);
      end
      step();
    end
    #1;
    checks++;
    if (ctl !== 5'b11100) begin
      errors++; $display("FAIL branch_retry got %b exp %b", ctl, 5'b11100);
    end
    step();
  endtask

  task automatic test_redirect();
    int sc0, fc0;
    idle(2);
    drive(1, 0, 0, 0, 0, 20, 1, 0, 0);
    step();
    sc0 = m_sc;
    fc0 = m_fc;
    drive(1, 20, 1, 0, 0, 0, 0, 1, 1);
    #1;
    checks++;
    if (ctl !== 5'b11111) begin
      errors++; $display("FAIL redirect got %b exp %b", ctl, 5'b11111);
    end
    step();
    drive(1, 20, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== 5'b11110) begin
      errors++; $display("FAIL redirect_flush got %b exp %b", ctl, 5'b11110);
    end
    checks++;
    if (bus.flush_cnt !== exp_cnt(fc0 + 1) || bus.stall_cnt !== exp_cnt(sc0)) begin
      errors++; $display("FAIL redirect_cnt got %h/%h exp %h/%h", bus.stall_cnt, bus.flush_cnt,
                         exp_cnt(sc0), exp_cnt(fc0 + 1));
    end
    step();
    #1;
    checks++;
    if (ctl !== 5'b11000) begin
      errors++; $display("FAIL redirect_sb_clear got %b exp %b", ctl, 5'b11000);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 9) < 6, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      #1;
      model_eval();
      checks++;
      if (ctl !== e_ctl) begin
        errors++; $display("FAIL rand_ctl cyc %0d got %b exp %b", i, ctl, e_ctl);
      end
      checks++;
      if (bus.stall_cnt !== exp_cnt(m_sc) || bus.flush_cnt !== exp_cnt(m_fc)) begin
        errors++; $display("FAIL rand_cnt cyc %0d got %h/%h exp %h/%h", i, bus.stall_cnt,
                           bus.flush_cnt, exp_cnt(m_sc), exp_cnt(m_fc));
      end
      step();
    end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_saturation();
    idle(2);
`ifdef PIPE_PERF_CNT_EN
    force dut.stall_cnt_r = 16'hFFFE;
    #1;
    release dut.stall_cnt_r;
    m_sc = 65534;
`endif
    for (int i = 0; i < 6; i++) begin
      drive(1, 7, 1, 0, 0, 7, 1, 0, 0);
      step();
    end
    #1;
    checks++;
    if (bus.stall_cnt !== (PERF ? 16'hFFFF : 16'h0000)) begin
      errors++; $display("FAIL stall_sat got %h exp %h", bus.stall_cnt, PERF ? 16'hFFFF : 16'h0000);
    end
    checks++;
    if (bus.stall_cnt !== exp_cnt(m_sc)) begin
      errors++; $display("FAIL stall_sat_model got %h exp %h", bus.stall_cnt, exp_cnt(m_sc));
    end
    idle(2);
  endtask

  task automatic test_reset_abort();
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== 5'b11110) begin
      errors++; $display("FAIL abort_in_flush got %b exp %b", ctl, 5'b11110);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b00111 || bus.stall_cnt !== 16'h0000 || bus.flush_cnt !== 16'h0000) begin
      errors++; $display("FAIL abort_reset got %b %h/%h exp 00111 0000/0000", ctl,
                         bus.stall_cnt, bus.flush_cnt);
    end
    step();
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== 5'b11000) begin
      errors++; $display("FAIL abort_release got %b exp %b", ctl, 5'b11000);
    end
    step();
  endtask

  initial begin
    m_ex = -1; m_wb = -1; m_fl = 0; m_sc = 0; m_fc = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_raw_stall();
    test_wb_distance();
    test_branch();
    test_redirect();
    test_random();
    test_saturation();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the four-stage CPU (IF → IF_ID → ID → ID_EX_M → EX_M → EX_M_WB → WB). Without forwarding, it keeps a two-slot scoreboard of in-flight destination registers and stalls ID on read-after-write hazards. It also squashes wrong-path instructions on ID branches and WB jumps (J/JM). It drives only enable, flush and bubble controls to the PC and the pipeline registers; it has no datapath of its own.

## Interface
- REG_W, 6: register specifier width (64-entry register file)
- REDIRECT_PENALTY, 2: cycles IF_ID is held flushed after a WB redirect; legal range 1..7
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_a, id_rs_b  in  REG_W  source specifiers of the ID instruction
- id_use_a, id_use_b  in  1  the ID instruction reads rs_a / rs_b
- id_rd  in  REG_W  destination specifier of the ID instruction
- id_reg_write  in  1  the ID instruction writes rd
- id_branch_taken  in  1  branch resolved taken in ID (IDBranch)
- wb_redirect  in  1  jump taken in WB (WBJump | WBJumpM)
- pc_en  out  1  PC may advance
- ifid_en  out  1  IF_ID may load
- ifid_flush  out  1  IF_ID loads a NOP
- idex_bubble  out  1  ID_EX_M loads a NOP
- exwb_flush  out  1  EX_M_WB loads a NOP
- stall_cnt  out  16  saturating count of hazard-stall cycles
- flush_cnt  out  16  saturating count of redirect events

## Operation
- **Scoreboard.** Two slots mirror EX_M and WB: {ex_v, ex_rd} and {wb_v, wb_rd}.
  - Every edge: wb ← ex. Then ex ← {id_valid & id_reg_write & !idex_bubble, id_rd}.
  - On a redirect edge both slots are cleared.
- **Hazard.** hz = id_valid & ((id_use_a & match(id_rs_a)) | (id_use_b & match(id_rs_b))).
  - match(r) = (ex_v & ex_rd==r) | (wb_v & wb_rd==r).
  - WB matches also stall, because the register file writes at the WB edge with no read-through.
  - Register 0 is not special.
- **FSM states:** RUN and FLUSH, with a 3-bit counter fcnt.
- **RUN, decided in this priority order:**
  - wb_redirect → ifid_flush=1, idex_bubble=1, exwb_flush=1, pc_en=1 (PC loads the jump target). Go to FLUSH with fcnt=REDIRECT_PENALTY-1. flush_cnt++. If PENALTY=1, stay in RUN.
  - hz → pc_en=0, ifid_en=0, idex_bubble=1. stall_cnt++.
  - id_branch_taken (qualified by !hz) → ifid_flush=1, pc_en=1.
  - otherwise → pc_en=1, ifid_en=1, all flush/bubble outputs 0.
- **FLUSH:**
  - Outputs: ifid_flush=1, idex_bubble=1, pc_en=1, and id_* inputs are ignored.
  - fcnt decrements each cycle; the state returns to RUN when fcnt==0.
  - A new wb_redirect in FLUSH reloads fcnt and counts again.
- ifid_en is 1 whenever ifid_flush is 1.

## Timing
- **Reset.** While rst_n=0, outputs are forced combinationally: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, exwb_flush=1, counters=0. State=RUN, scoreboard empty.
- The first rising edge after rst_n rises behaves as RUN with an empty scoreboard.
- All control outputs are combinational from state, scoreboard and the current-cycle inputs, so they apply at the next rising edge. There is no added latency.
- **Stall length.**
  - A hazard with the producer in EX_M stalls 2 cycles.
  - A hazard with the producer in WB stalls 1 cycle.
- **Redirect penalty.** A redirect inserts 3 NOP stages plus REDIRECT_PENALTY-1 extra IF_ID NOPs.
- **Simultaneous events.**
  - wb_redirect beats hz and id_branch_taken; the stalled instruction is squashed.
  - hz beats id_branch_taken; the branch retries after the stall.
- Asserting rst_n=0 mid-stall or mid-FLUSH aborts immediately to the reset values.
- Both counters saturate at 16'hFFFF.

## Configuration
- **PIPE_PERF_CNT_EN defined:** stall_cnt and flush_cnt count as specified above.
- **PIPE_PERF_CNT_EN undefined:** the counter registers are removed and both ports are tied to 16'h0000. The ports are still present.

## Test plan
- **Reset.** Hold rst_n=0 for 3 cycles with id inputs toggling → pc_en=0, all flushes=1, counters=0. First edge after release → pc_en=1, ifid_en=1.
- **RAW stall.** id_rd=5 with reg_write, followed by rs_a=5 with use_a → exactly 2 cycles of pc_en=0 and idex_bubble=1, then issue; stall_cnt=2.
- **WB-distance hazard.** Producer, independent instruction, then consumer of the same register → 1 stall cycle. With use_a=0, no stall.
- **Branch.** id_branch_taken=1 with no hazard → one cycle of ifid_flush=1, pc_en=1; idex_bubble=0.
- **Redirect.** wb_redirect=1 with REDIRECT_PENALTY=2, coincident with a hazard → all three flushes this cycle, one more FLUSH cycle, scoreboard cleared, flush_cnt=1, stall_cnt unchanged.
- **Saturation and reset abort.** Force stall_cnt to 16'hFFFE and stall 3 cycles → 16'hFFFF. Pulse rst_n low mid-FLUSH → reset values immediately.
